// File: rtl/lock_pkg.sv
// Shared definitions for the lock sequencer: state encoding seen by the
// display driver, the factory-default code digit and a saturating counter helper.
package lock_pkg;

  // Encodings are visible on the state port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ENTRY  = 3'b001,
    ST_OPEN   = 3'b010,
    ST_ALARM  = 3'b011,
    ST_CHANGE = 3'b101
  } state_e;

  localparam logic [3:0] DEFAULT_DIGIT = 4'h6;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [1:0] sat_inc(input logic [1:0] val, input logic [1:0] limit);
    return (val >= limit) ? val : val + 2'd1;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a done flag; reused for the OPEN hold time and
// the ALARM lockout since the two are never active together.
module lock_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over counting; counting stops at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Digit-entry combination lock: compares a DIGITS-long entered sequence with a
// reprogrammable code store, opens for a while on success, and locks out with
// an alarm after MAX_FAIL consecutive failures. All outputs are registered.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] x,
  input  logic       enter,
  input  logic       change,
  output logic [2:0] state,
  output logic       open,
  output logic       alarm,
  output logic       new_mode,
  output logic [1:0] digit_idx,
  output logic [1:0] fail_cnt
);

  localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [1:0] LAST_IDX = 2'(DIGITS - 1);
  localparam logic [1:0] FAIL_LIM = 2'(MAX_FAIL);
  // The timer holds N-1 on entry and the exit happens on the edge after it
  // reaches zero, so the state is visible for exactly N cycles.
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] fail_q, fail_d;
  logic       err_q, err_d;
  logic       open_q, alarm_q, new_mode_q;
  logic [3:0] code_q [DIGITS];

  logic          err_acc;
  logic          code_we;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_en;
  logic          tmr_done;

  lock_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // Next-state, counters and timer control; enter always outranks change.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    fail_d       = fail_q;
    err_d        = err_q;
    err_acc      = err_q | (x != code_q[idx_q]);
    code_we      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enter) begin
          err_d   = (x != code_q[0]);
          idx_d   = 2'd1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (enter) begin
          err_d = err_acc;
          if (idx_q == LAST_IDX) begin
            idx_d = 2'd0;
            if (!err_acc) begin
              state_d      = ST_OPEN;
              fail_d       = 2'd0;
              tmr_load     = 1'b1;
              tmr_load_val = OPEN_LOAD;
            end else begin
              fail_d = sat_inc(fail_q, FAIL_LIM);
              if (fail_d == FAIL_LIM) begin
                state_d      = ST_ALARM;
                tmr_load     = 1'b1;
                tmr_load_val = LOCK_LOAD;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (change) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end
      end
      ST_OPEN: begin
        tmr_en = 1'b1;
        if (enter) begin
          state_d = ST_IDLE;
        end else if (change) begin
          state_d = ST_CHANGE;
          idx_d   = 2'd0;
        end else if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (enter) begin
          code_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (change) begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end
      end
      ST_ALARM: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d = ST_IDLE;
          fail_d  = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State, counters and registered decode of the mode flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      fail_q     <= 2'd0;
      err_q      <= 1'b0;
      open_q     <= 1'b0;
      alarm_q    <= 1'b0;
      new_mode_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      open_q     <= (state_d == ST_OPEN);
      alarm_q    <= (state_d == ST_ALARM);
      new_mode_q <= (state_d == ST_CHANGE);
    end
  end

  // Code store; written one digit per enter while in CHANGE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this small store is built from flops and must come back to the
      // factory code on reset, so it is reset like any other register.
      for (int i = 0; i < DIGITS; i++) begin
        code_q[i] <= DEFAULT_DIGIT;
      end
    end else if (code_we) begin
      code_q[idx_q] <= x;
    end
  end

  assign state     = state_q;
  assign open      = open_q;
  assign alarm     = alarm_q;
  assign new_mode  = new_mode_q;
  assign digit_idx = idx_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus randomized
// traffic, all compared cycle by cycle with a queue-based behavioural model.
module tb_lock_sequencer;

  localparam int DIGITS      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYCLES = 8;
  localparam int LOCK_CYCLES = 16;

  localparam int P_IDLE   = 0;
  localparam int P_ENTRY  = 1;
  localparam int P_OPEN   = 2;
  localparam int P_ALARM  = 3;
  localparam int P_CHANGE = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] x = 4'h0;
  logic       enter = 1'b0;
  logic       change = 1'b0;
  logic [2:0] state;
  logic       open;
  logic       alarm;
  logic       new_mode;
  logic [1:0] digit_idx;
  logic [1:0] fail_cnt;

  int total = 0;
  int bad = 0;

  lock_sequencer #(
    .DIGITS      (DIGITS),
    .MAX_FAIL    (MAX_FAIL),
    .OPEN_CYCLES (OPEN_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .enter     (enter),
    .change    (change),
    .state     (state),
    .open      (open),
    .alarm     (alarm),
    .new_mode  (new_mode),
    .digit_idx (digit_idx),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: the attempt is a queue of digits checked as a whole.
  int m_code [DIGITS];
  int m_att [$];
  int m_phase;
  int m_fail;
  int m_left;
  int m_wr;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DIGITS; i++) m_code[i] = 6;
    m_att.delete();
    m_phase = P_IDLE;
    m_fail  = 0;
    m_left  = 0;
    m_wr    = 0;
  endfunction

  function automatic void model_step(input bit en, input bit ch, input int xv);
    bit ok;
    case (m_phase)
      P_IDLE: if (en) begin
        m_att.delete();
        m_att.push_back(xv);
        m_phase = P_ENTRY;
      end
      P_ENTRY: if (en) begin
        m_att.push_back(xv);
        if (m_att.size() == DIGITS) begin
          ok = 1'b1;
          for (int i = 0; i < DIGITS; i++) if (m_att[i] != m_code[i]) ok = 1'b0;
          m_att.delete();
          if (ok) begin
            m_phase = P_OPEN;
            m_fail  = 0;
            m_left  = OPEN_CYCLES;
          end else begin
            if (m_fail < MAX_FAIL) m_fail++;
            if (m_fail == MAX_FAIL) begin
              m_phase = P_ALARM;
              m_left  = LOCK_CYCLES;
            end else begin
              m_phase = P_IDLE;
            end
          end
        end
      end else if (ch) begin
        m_att.delete();
        m_phase = P_IDLE;
      end
      P_OPEN: begin
        if (en) m_phase = P_IDLE;
        else if (ch) begin
          m_phase = P_CHANGE;
          m_wr    = 0;
        end else begin
          m_left--;
          if (m_left == 0) m_phase = P_IDLE;
        end
      end
      P_CHANGE: begin
        if (en) begin
          m_code[m_wr] = xv;
          m_wr++;
          if (m_wr == DIGITS) begin
            m_wr    = 0;
            m_phase = P_IDLE;
          end
        end else if (ch) begin
          m_wr    = 0;
          m_phase = P_IDLE;
        end
      end
      P_ALARM: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = P_IDLE;
          m_fail  = 0;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endfunction

  function automatic int exp_idx();
    if (m_phase == P_ENTRY) return m_att.size();
    if (m_phase == P_CHANGE) return m_wr;
    return 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".state"},     8'(state),     8'(m_phase));
    check({tag, ".open"},      8'(open),      8'(m_phase == P_OPEN));
    check({tag, ".alarm"},     8'(alarm),     8'(m_phase == P_ALARM));
    check({tag, ".new_mode"},  8'(new_mode),  8'(m_phase == P_CHANGE));
    check({tag, ".digit_idx"}, 8'(digit_idx), 8'(exp_idx()));
    check({tag, ".fail_cnt"},  8'(fail_cnt),  8'(m_fail));
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // compare shortly after it.
  task automatic cycle(input bit en, input bit ch, input logic [3:0] xv);
    @(negedge clk);
    enter  = en;
    change = ch;
    x      = xv;
    @(posedge clk);
    model_step(en, ch, int'(xv));
    #1;
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0);
  endtask

  // Asynchronous reset asserted between edges and checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    enter  = 1'b0;
    change = 1'b0;
    reset  = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic enter_seq(input logic [15:0] digits);
    for (int i = 0; i < DIGITS; i++) cycle(1'b1, 1'b0, digits[15 - 4*i -: 4]);
  endtask

  initial begin
    logic [3:0] xv;
    bit en, ch;

    model_reset();
    do_reset();
    check("reset.state", 8'(state), 8'h00);
    check("reset.flags", 8'({open, alarm, new_mode}), 8'h00);
    check("reset.counts", 8'({digit_idx, fail_cnt}), 8'h00);

    // Default code opens, then relocks after OPEN_CYCLES.
    enter_seq(16'h6666);
    check("open.state", 8'(state), 8'h02);
    check("open.flag", 8'(open), 8'h01);
    idle(OPEN_CYCLES - 1);
    check("open.held", 8'(open), 8'h01);
    idle(1);
    check("open.relock", 8'(state), 8'h00);

    // Three wrong attempts raise the alarm; enter pulses in ALARM are ignored.
    enter_seq(16'h6656);
    check("fail1.cnt", 8'(fail_cnt), 8'h01);
    check("fail1.state", 8'(state), 8'h00);
    enter_seq(16'h6656);
    enter_seq(16'h6656);
    check("alarm.flag", 8'(alarm), 8'h01);
    check("alarm.cnt", 8'(fail_cnt), 8'h03);
    for (int i = 0; i < LOCK_CYCLES - 1; i++) cycle(i[0], 1'b0, 4'h6);
    check("alarm.held", 8'(alarm), 8'h01);
    idle(1);
    check("alarm.exit", 8'({state, alarm}), 8'h00);
    check("alarm.clear", 8'(fail_cnt), 8'h00);

    // Code change to 1,2,3,4; old code then fails and new one opens.
    enter_seq(16'h6666);
    cycle(1'b0, 1'b1, 4'h0);
    check("chg.new_mode", 8'(new_mode), 8'h01);
    enter_seq(16'h1234);
    check("chg.done", 8'({state, new_mode}), 8'h00);
    enter_seq(16'h6666);
    check("chg.oldfails", 8'(fail_cnt), 8'h01);
    enter_seq(16'h1234);
    check("chg.newopens", 8'(open), 8'h01);
    idle(OPEN_CYCLES);

    // Abort mid-entry keeps fail_cnt; simultaneous enter+change counts as enter.
    enter_seq(16'h9999);
    cycle(1'b1, 1'b0, 4'h1);
    cycle(1'b1, 1'b0, 4'h2);
    check("abort.mid_idx", 8'(digit_idx), 8'h02);
    cycle(1'b0, 1'b1, 4'h0);
    check("abort.state", 8'(state), 8'h00);
    check("abort.idx", 8'(digit_idx), 8'h00);
    check("abort.fail", 8'(fail_cnt), 8'h01);
    cycle(1'b1, 1'b1, 4'h1);
    check("both.entry", 8'(state), 8'h01);
    cycle(1'b1, 1'b1, 4'h2);
    check("both.idx", 8'(digit_idx), 8'h02);
    cycle(1'b1, 1'b0, 4'h3);
    cycle(1'b1, 1'b0, 4'h4);
    check("both.open", 8'(open), 8'h01);

    // Reset mid-entry restores the default code.
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h1);
    cycle(1'b1, 1'b0, 4'h2);
    do_reset();
    check("rst.mid_entry", 8'({state, open, alarm, new_mode, digit_idx}), 8'h00);
    enter_seq(16'h6666);
    check("rst.code_restored", 8'(open), 8'h01);

    // Randomized traffic, biased toward the current code so all paths occur.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        en = ($urandom_range(1) == 1);
        ch = ($urandom_range(7) == 0);
        if (m_phase != P_CHANGE && $urandom_range(3) != 0) begin
          xv = 4'(m_code[(m_phase == P_ENTRY) ? m_att.size() : 0]);
        end else begin
          xv = 4'($urandom_range(15));
        end
        cycle(en, ch, xv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of code digits per attempt.
REQ-002 SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive failed attempts that triggers ALARM.
REQ-003 SHALL have parameter OPEN_CYCLES, default 8, meaning the number of cycles OPEN is held before it auto-relocks.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, meaning the ALARM lockout duration in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port x, input, 4 bits: the digit currently presented.
REQ-008 SHALL have port enter, input, 1 bit: single-cycle pulse (already conditioned) that submits x.
REQ-009 SHALL have port change, input, 1 bit: single-cycle pulse (already conditioned) that requests a code change or aborts entry.
REQ-010 SHALL have port state, output, 3 bits: encoded state for the display driver.
REQ-011 SHALL have port open, output, 1 bit: high while in OPEN.
REQ-012 SHALL have port alarm, output, 1 bit: high while in ALARM.
REQ-013 SHALL have port new_mode, output, 1 bit: high while in CHANGE.
REQ-014 SHALL have port digit_idx, output, 2 bits: index of the next digit expected.
REQ-015 SHALL have port fail_cnt, output, 2 bits: count of consecutive failed attempts.

Function
REQ-016 SHALL encode state as IDLE 000, ENTRY 001, OPEN 010, ALARM 011, LOCKOUT-free CHANGE 101; all other codes are illegal and SHALL recover to IDLE on the next edge.
REQ-017 SHALL hold an internal code store of DIGITS 4-bit entries.
REQ-018 All outputs SHALL be registered, with a one-cycle latency from the sampled pulse edge to the output change.
REQ-019 IDLE + enter: compare x with code[0], set err to (x != code[0]), set digit_idx to 1, go to ENTRY.
REQ-020 ENTRY + enter: set err to err OR (x != code[digit_idx]), then increment digit_idx.
REQ-021 On the DIGITS-th enter with err clear (this digit's compare included), SHALL go to OPEN, clear fail_cnt, and reset digit_idx to 0.
REQ-022 On the DIGITS-th enter with err set, fail_cnt SHALL increment; if the new fail_cnt equals MAX_FAIL, go to ALARM, otherwise go to IDLE; digit_idx SHALL return to 0.
REQ-023 A change pulse in ENTRY SHALL abort to IDLE with digit_idx 0 and fail_cnt unchanged.
REQ-024 OPEN + change SHALL go to CHANGE with digit_idx 0.
REQ-025 OPEN + enter, or expiry of OPEN_CYCLES, SHALL go to IDLE.
REQ-026 CHANGE + enter SHALL write x into code[digit_idx] and increment digit_idx; after the DIGITS-th write, go to IDLE.
REQ-027 CHANGE + change SHALL abort to IDLE, keeping any digits already written.
REQ-028 ALARM SHALL ignore enter and change, and after LOCK_CYCLES SHALL go to IDLE with fail_cnt cleared.
REQ-029 When enter and change are high in the same cycle, enter SHALL take priority; change is then ignored.
REQ-030 fail_cnt SHALL saturate and never wrap past MAX_FAIL.
REQ-031 digit_idx SHALL wrap to 0 on every exit from ENTRY or CHANGE.

Reset
REQ-032 Asserting reset SHALL asynchronously set the following values:
- state to IDLE
- open, alarm and new_mode to 0
- digit_idx and fail_cnt to 0
- err to 0
- the timer to 0
- every code entry to 4'h6
REQ-033 Asserting reset mid-ENTRY, mid-CHANGE or mid-ALARM SHALL discard the operation in progress, including any partially written code.

Structure
REQ-034 The package lock_pkg SHALL hold the state encoding constants and the default code digit (4'h6).
REQ-035 A single sub-module lock_timer SHALL implement a loadable down-counter with a done flag, shared by OPEN and ALARM.

Verification
REQ-036 Reset, then enter 6,6,6,6 -> OPEN (state 010, open 1) on the cycle after the 4th pulse; auto-return to IDLE 8 cycles later.
REQ-037 Enter 6,6,5,6 -> IDLE with fail_cnt 1; three such attempts -> alarm 1 for 16 cycles, then IDLE with fail_cnt 0; enter pulses during ALARM have no effect.
REQ-038 Open the lock, pulse change, enter 1,2,3,4 -> IDLE; then 6,6,6,6 fails and 1,2,3,4 opens.
REQ-039 In ENTRY after 2 digits, pulse change -> IDLE with digit_idx 0 and fail_cnt unchanged; pulse enter and change together in IDLE -> ENTRY.
REQ-040 Change code to 1,2,3,4, assert reset mid-ENTRY -> all outputs 0 and the code is restored to 6,6,6,6.
